// File: rtl/serial_adder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : serial_adder_pkg
// Description : Shared types and constants for the bit-serial adder.
//               Holds the FSM state encoding, the legal WIDTH bounds and a
//               helper that sizes the bit counter for a given WIDTH.
// Revision    : 1.0 - initial release
// ============================================================================
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int c_width_min = 2;
  localparam int c_width_max = 32;

  // Bit-counter width. The floor of 1 keeps the vector legal for any WIDTH.
  function automatic int cnt_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/serial_adder_bit_adder_cell.sv
`default_nettype none
// ============================================================================
// Module      : bit_adder_cell
// Description : Combinational one-bit full adder made of two half-adder
//               slices whose carries are ORed together.
// Ports       : a, b, cin (in)  - addend bits and carry-in
//               s         (out) - sum bit
//               c         (out) - carry-out
// Revision    : 1.0 - initial release
// ============================================================================
module bit_adder_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic c
);

  logic w_h1_s;
  logic w_h1_c;
  logic w_h2_c;

  // First half-adder slice: a + b
  assign w_h1_s = a ^ b;
  assign w_h1_c = a & b;

  // Second half-adder slice: partial sum + carry-in
  assign s      = w_h1_s ^ cin;
  assign w_h2_c = w_h1_s & cin;

  // At most one slice can generate a carry, so OR equals the majority.
  assign c      = w_h1_c | w_h2_c;

endmodule
`default_nettype wire

// File: rtl/serial_adder.sv
`default_nettype none
// ============================================================================
// Module      : serial_adder
// Description : Bit-serial WIDTH-bit adder. Operands are captured on an
//               accepted start, shifted LSB-first through one full-adder cell
//               with a registered carry, and the result is presented with a
//               one-cycle done pulse.
// Config      : SERIAL_ADDER_SUB_EN - adds the sub port; sub=1 at capture
//               computes a_in - b_in (cout=1 means no borrow).
// Ports       : clk, rst_n (async, active-low)
//               start        - request, sampled only in IDLE
//               a_in, b_in   - operands, captured on the accepted start
//               sub          - subtract select (SERIAL_ADDER_SUB_EN only)
//               busy         - high in RUN and DONE
//               done         - one-cycle completion pulse
//               sum, cout    - result, held until the next completion
// Revision    : 1.0 - initial release
// ============================================================================
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int                 c_cnt_w = cnt_width(WIDTH);
  localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(WIDTH - 1);

  if (WIDTH < c_width_min || WIDTH > c_width_max) begin : g_bad_width
    $error("serial_adder: WIDTH out of range");
  end

  state_t             r_state;
  logic [WIDTH-1:0]   r_a_sr;
  logic [WIDTH-1:0]   r_b_sr;
  logic [WIDTH-1:0]   r_ps;
  logic               r_carry;
  logic [c_cnt_w-1:0] r_cnt;

  logic               w_b_bit;
  logic               w_s;
  logic               w_c;
  logic [WIDTH-1:0]   w_ps_next;
  logic               w_carry_init;

`ifdef SERIAL_ADDER_SUB_EN
  logic r_sub;

  // Subtraction is a + ~b + 1: invert b in the cell, seed the carry with 1.
  assign w_b_bit      = r_b_sr[0] ^ r_sub;
  assign w_carry_init = sub;
`else
  assign w_b_bit      = r_b_sr[0];
  assign w_carry_init = 1'b0;
`endif

  bit_adder_cell u_cell (
    .a   (r_a_sr[0]),
    .b   (w_b_bit),
    .cin (r_carry),
    .s   (w_s),
    .c   (w_c)
  );

  // New sum bit enters at the MSB, so after WIDTH shifts bit 0 sits at LSB.
  assign w_ps_next = {w_s, r_ps[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_a_sr  <= '0;
      r_b_sr  <= '0;
      r_ps    <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      sum     <= '0;
      cout    <= 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
      r_sub   <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_a_sr  <= a_in;
            r_b_sr  <= b_in;
            r_carry <= w_carry_init;
            r_cnt   <= '0;
            busy    <= 1'b1;
`ifdef SERIAL_ADDER_SUB_EN
            r_sub   <= sub;
`endif
            r_state <= RUN;
          end
        end
        RUN: begin
          r_carry <= w_c;
          r_a_sr  <= r_a_sr >> 1;
          r_b_sr  <= r_b_sr >> 1;
          r_ps    <= w_ps_next;
          r_cnt   <= r_cnt + c_cnt_w'(1);
          // Result registers update only here, so they never show partials.
          if (r_cnt == c_last) begin
            sum     <= w_ps_next;
            cout    <= w_c;
            done    <= 1'b1;
            r_state <= DONE;
          end
        end
        DONE: begin
          busy    <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          busy    <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_serial_adder.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_adder
// Description : Directed self-checking bench for serial_adder (WIDTH=8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_adder;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
`ifdef SERIAL_ADDER_SUB_EN
  logic             sub;
`endif
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  int tests_run;
  int tests_failed;

  serial_adder #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a_in  (a_in),
    .b_in  (b_in),
`ifdef SERIAL_ADDER_SUB_EN
    .sub   (sub),
`endif
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse start for one edge; returns at the negedge just after the accept edge.
  task automatic launch(input logic [7:0] a, input logic [7:0] b, input logic s);
    @(negedge clk);
    a_in  = a;
    b_in  = b;
`ifdef SERIAL_ADDER_SUB_EN
    sub   = s;
`endif
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if (s) begin end
  endtask

  // Waits for done (bounded); lat = edges after the accept edge.
  task automatic wait_done(output int lat, output bit timed_out);
    lat = 0;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    timed_out = !done;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    start = 1'b0;
    a_in  = '0;
    b_in  = '0;
`ifdef SERIAL_ADDER_SUB_EN
    sub   = 1'b0;
`endif
    @(negedge clk);
    @(negedge clk);
    tests_run++;
    if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b expected 0", busy); end
    tests_run++;
    if (done !== 1'b0) begin tests_failed++; $display("FAIL reset_done: got %b expected 0", done); end
    tests_run++;
    if (sum !== 8'h00) begin tests_failed++; $display("FAIL reset_sum: got %h expected 00", sum); end
    tests_run++;
    if (cout !== 1'b0) begin tests_failed++; $display("FAIL reset_cout: got %b expected 0", cout); end
    rst_n = 1'b1;
  endtask

  // 0x5A + 0x33: check timing of busy/done and hold of sum mid-run.
  task automatic test_basic;
    int busy_cnt, done_cnt, done_k;
    logic [7:0] mid_sum;
    busy_cnt = 0; done_cnt = 0; done_k = -1; mid_sum = 8'hxx;
    launch(8'h5A, 8'h33, 1'b0);
    for (int k = 0; k < 16; k++) begin
      if (busy) busy_cnt++;
      if (done) begin done_cnt++; done_k = k; end
      if (k == 4) mid_sum = sum;
      @(negedge clk);
    end
    tests_run++;
    if (done_k !== WIDTH) begin tests_failed++; $display("FAIL basic_latency: got %0d expected %0d", done_k, WIDTH); end
    tests_run++;
    if (done_cnt !== 1) begin tests_failed++; $display("FAIL basic_done_pulses: got %0d expected 1", done_cnt); end
    tests_run++;
    if (busy_cnt !== WIDTH + 1) begin tests_failed++; $display("FAIL basic_busy_cycles: got %0d expected %0d", busy_cnt, WIDTH + 1); end
    tests_run++;
    if (mid_sum !== 8'h00) begin tests_failed++; $display("FAIL basic_mid_sum_hold: got %h expected 00", mid_sum); end
    tests_run++;
    if (sum !== 8'h8D) begin tests_failed++; $display("FAIL basic_sum: got %h expected 8d", sum); end
    tests_run++;
    if (cout !== 1'b0) begin tests_failed++; $display("FAIL basic_cout: got %b expected 0", cout); end
  endtask

  task automatic test_edges;
    logic [7:0] ta [4];
    logic [7:0] tb [4];
    logic [7:0] ts [4];
    logic       tc [4];
    int  lat;
    bit  to;
    ta = '{8'hFF, 8'h00, 8'hFF, 8'h80};
    tb = '{8'h01, 8'h00, 8'hFF, 8'h80};
    ts = '{8'h00, 8'h00, 8'hFE, 8'h00};
    tc = '{1'b1,  1'b0,  1'b1,  1'b1};
    for (int i = 0; i < 4; i++) begin
      launch(ta[i], tb[i], 1'b0);
      wait_done(lat, to);
      tests_run++;
      if (to) begin
        tests_failed++;
        $display("FAIL edge_%0d_timeout: got no done expected done", i);
      end else if (sum !== ts[i] || cout !== tc[i]) begin
        tests_failed++;
        $display("FAIL edge_%0d_result: got %b_%h expected %b_%h", i, cout, sum, tc[i], ts[i]);
      end
      @(negedge clk);
    end
  endtask

  // start held high, operands rotate each edge; accepts at edges 0, 10, 20.
  task automatic test_back_to_back;
    logic [7:0] sa [3];
    logic [7:0] sb [3];
    logic [7:0] es [3];
    logic       ec [3];
    int n_done;
    sa = '{8'h5A, 8'hC8, 8'h0F};
    sb = '{8'h33, 8'h64, 8'hF1};
    es = '{8'h8D, 8'h2C, 8'h00};
    ec = '{1'b0,  1'b1,  1'b1};
    n_done = 0;
    @(negedge clk);
    for (int j = 0; j < 30; j++) begin
      a_in  = sa[j % 3];
      b_in  = sb[j % 3];
      start = 1'b1;
      @(negedge clk);
      if (done) begin
        tests_run++;
        if (n_done > 2 || j !== 8 + 10 * n_done) begin
          tests_failed++;
          $display("FAIL b2b_timing: got done after edge %0d expected %0d", j, 8 + 10 * n_done);
        end else if (sum !== es[n_done] || cout !== ec[n_done]) begin
          tests_failed++;
          $display("FAIL b2b_result_%0d: got %b_%h expected %b_%h", n_done, cout, sum, ec[n_done], es[n_done]);
        end
        n_done++;
      end
    end
    start = 1'b0;
    tests_run++;
    if (n_done !== 3) begin tests_failed++; $display("FAIL b2b_count: got %0d expected 3", n_done); end
    @(negedge clk);
    @(negedge clk);
    tests_run++;
    if (busy !== 1'b0) begin tests_failed++; $display("FAIL b2b_idle_after: got busy=%b expected 0", busy); end
  endtask

  task automatic test_reset_midrun;
    int n_done, lat;
    bit to;
    n_done = 0;
    launch(8'h5A, 8'h33, 1'b0);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (busy !== 1'b0 || done !== 1'b0 || sum !== 8'h00 || cout !== 1'b0) begin
      tests_failed++;
      $display("FAIL midrun_reset_clear: got busy=%b done=%b sum=%h cout=%b expected all 0", busy, done, sum, cout);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      if (done) n_done++;
    end
    tests_run++;
    if (n_done !== 0) begin tests_failed++; $display("FAIL midrun_no_done: got %0d pulses expected 0", n_done); end
    launch(8'h5A, 8'h33, 1'b0);
    wait_done(lat, to);
    tests_run++;
    if (to || sum !== 8'h8D || cout !== 1'b0) begin
      tests_failed++;
      $display("FAIL midrun_restart: got %b_%h (timeout=%b) expected 0_8d", cout, sum, to);
    end
    @(negedge clk);
  endtask

  task automatic test_operand_change;
    int lat;
    bit to;
    launch(8'h3C, 8'h25, 1'b0);
    lat = 0;
    while (!done && lat < 40) begin
      a_in = a_in + 8'h37;
      b_in = ~b_in;
      @(negedge clk);
      lat++;
    end
    to = !done;
    tests_run++;
    if (to || sum !== 8'h61 || cout !== 1'b0) begin
      tests_failed++;
      $display("FAIL operand_change: got %b_%h (timeout=%b) expected 0_61", cout, sum, to);
    end
    @(negedge clk);
  endtask

`ifdef SERIAL_ADDER_SUB_EN
  task automatic test_sub;
    int lat;
    bit to;
    launch(8'h10, 8'h01, 1'b1);
    wait_done(lat, to);
    tests_run++;
    if (to || sum !== 8'h0F || cout !== 1'b1) begin
      tests_failed++;
      $display("FAIL sub_no_borrow: got %b_%h expected 1_0f", cout, sum);
    end
    launch(8'h01, 8'h02, 1'b1);
    wait_done(lat, to);
    tests_run++;
    if (to || sum !== 8'hFF || cout !== 1'b0) begin
      tests_failed++;
      $display("FAIL sub_borrow: got %b_%h expected 0_ff", cout, sum);
    end
    sub = 1'b0;
    @(negedge clk);
  endtask
`endif

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    test_reset();
    test_basic();
    test_edges();
    test_back_to_back();
    test_reset_midrun();
    test_operand_change();
`ifdef SERIAL_ADDER_SUB_EN
    test_sub();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire
